// File: rtl/game_countdown_timers.sv
// Ready (R) and play (P) second countdowns for the game controller.
// Each channel has its own prescaler and IDLE/RUN/DONE FSM; all outputs are registered.
module game_countdown_timers #(
   parameter int TICK_DIV   = 100000000,
   parameter int READY_SECS = 5,
   parameter int PLAY_SECS  = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       timer_5_start,
   input  logic       timer_30_start,
   input  logic       pause,
   output logic [2:0] timer_5_out,
   output logic [4:0] timer_30_out,
   output logic       ready_done,
   output logic       play_expired
);
   localparam int NUM_CH = 2;
   localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   logic [NUM_CH-1:0] start;
   assign start = {timer_30_start, timer_5_start};

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam int CW   = (g == 0) ? 3 : 5;
      localparam int LOAD = (g == 0) ? READY_SECS : PLAY_SECS;

      state_e          state_q, state_d;
      logic [CW-1:0]   cnt_q, cnt_d;
      logic [PW-1:0]   pre_q, pre_d;
      logic            done_q, done_d;

      always_ff @(posedge clk) begin
         if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= CW'(LOAD);
            pre_q   <= '0;
            done_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         pre_d   = pre_q;
         done_d  = 1'b0;
         unique case (state_q)
            IDLE: begin
               cnt_d = CW'(LOAD);
               pre_d = '0;
               if (start[g]) state_d = RUN;
            end
            RUN: begin
               // Abort wins over a decrement landing on the same edge.
               if (!start[g]) begin
                  state_d = IDLE;
                  cnt_d   = CW'(LOAD);
                  pre_d   = '0;
               end else if (!pause) begin
                  if (pre_q == PW'(TICK_DIV - 1)) begin
                     pre_d = '0;
                     cnt_d = cnt_q - 1'b1;
                     if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                     end
                  end else begin
                     pre_d = pre_q + 1'b1;
                  end
               end
            end
            DONE: begin
               cnt_d = '0;
               pre_d = '0;
               if (!start[g]) begin
                  state_d = IDLE;
                  cnt_d   = CW'(LOAD);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = CW'(LOAD);
               pre_d   = '0;
            end
         endcase
      end

      if (g == 0) begin : g_ready
         assign timer_5_out = cnt_q;
         assign ready_done  = done_q;
      end else begin : g_play
         assign timer_30_out = cnt_q;
         assign play_expired = done_q;
      end
   end

endmodule

// File: tb/tb_game_countdown_timers.sv
// Directed bench for game_countdown_timers with TICK_DIV=4, READY_SECS=5, PLAY_SECS=30.
module tb_game_countdown_timers;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       t5_start = 1'b0;
   logic       t30_start = 1'b0;
   logic       pause = 1'b0;
   logic [2:0] timer_5_out;
   logic [4:0] timer_30_out;
   logic       ready_done;
   logic       play_expired;

   int checks = 0;
   int failures = 0;

   game_countdown_timers #(.TICK_DIV(4), .READY_SECS(5), .PLAY_SECS(30)) dut (
      .clk           (clk),
      .reset         (reset),
      .timer_5_start (t5_start),
      .timer_30_start(t30_start),
      .pause         (pause),
      .timer_5_out   (timer_5_out),
      .timer_30_out  (timer_30_out),
      .ready_done    (ready_done),
      .play_expired  (play_expired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Advance n rising edges and settle just past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int bad;
      int pulses;

      // 1: reset and idle stability
      step(2);
      chk("rst_t5", timer_5_out, 5);
      chk("rst_t30", timer_30_out, 30);
      chk("rst_rd", ready_done, 0);
      chk("rst_pe", play_expired, 0);
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (timer_5_out != 5 || timer_30_out != 30 || ready_done || play_expired) bad++;
      end
      chk("idle_stable_bad_cycles", bad, 0);

      // 2: ready countdown
      t5_start = 1'b1;
      step(1);
      chk("r_entry", timer_5_out, 5);
      for (int s = 4; s >= 0; s--) begin
         step(3);
         chk("r_hold", timer_5_out, s + 1);
         chk("r_hold_pulse", ready_done, 0);
         step(1);
         chk("r_step", timer_5_out, s);
         chk("r_step_pulse", ready_done, (s == 0) ? 1 : 0);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (timer_5_out != 0 || ready_done) bad++;
      end
      chk("r_done_hold_bad", bad, 0);
      chk("r_t30_untouched", timer_30_out, 30);
      t5_start = 1'b0;
      step(1);
      chk("r_reload", timer_5_out, 5);

      // 3: play countdown to expiry, start held high afterwards
      t30_start = 1'b1;
      step(1);
      step(119);
      chk("p_pre_exp_cnt", timer_30_out, 1);
      chk("p_pre_exp_pulse", play_expired, 0);
      step(1);
      chk("p_exp_pulse", play_expired, 1);
      chk("p_exp_cnt", timer_30_out, 0);
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (timer_30_out != 0 || play_expired) bad++;
      end
      chk("p_no_rerun_bad", bad, 0);
      t30_start = 1'b0;
      step(1);
      chk("p_reload", timer_30_out, 30);

      // 4: pause mid-run
      t30_start = 1'b1;
      step(1);
      step(12);
      chk("pz_27", timer_30_out, 27);
      pause = 1'b1;
      bad = 0;
      for (int i = 0; i < 9; i++) begin
         step(1);
         if (timer_30_out != 27) bad++;
      end
      chk("pz_hold_bad", bad, 0);
      pause = 1'b0;
      step(3);
      chk("pz_post3", timer_30_out, 27);
      step(1);
      chk("pz_post4", timer_30_out, 26);
      t30_start = 1'b0;
      step(1);
      chk("pz_abort_reload", timer_30_out, 30);

      // 4b: pause held across the IDLE->RUN edge
      pause = 1'b1;
      t30_start = 1'b1;
      step(1);
      step(6);
      chk("pz_entry_hold", timer_30_out, 30);
      pause = 1'b0;
      step(3);
      chk("pz_entry_3", timer_30_out, 30);
      step(1);
      chk("pz_entry_4", timer_30_out, 29);
      t30_start = 1'b0;
      step(1);

      // 5: both channels together, then ready abort mid-run
      t5_start = 1'b1;
      t30_start = 1'b1;
      step(1);
      step(19);
      chk("b_t5_19", timer_5_out, 1);
      chk("b_t30_19", timer_30_out, 26);
      step(1);
      chk("b_rd_20", ready_done, 1);
      chk("b_t5_20", timer_5_out, 0);
      chk("b_t30_20", timer_30_out, 25);
      t5_start = 1'b0;
      step(1);
      chk("b_rd_21", ready_done, 0);
      chk("b_t5_21", timer_5_out, 5);
      t5_start = 1'b1;
      step(1);
      step(8);
      chk("b_t5_3", timer_5_out, 3);
      chk("b_t30_30", timer_30_out, 23);
      t5_start = 1'b0;
      step(1);
      chk("b_abort_t5", timer_5_out, 5);
      chk("b_abort_rd", ready_done, 0);
      chk("b_abort_t30", timer_30_out, 23);
      step(1);
      chk("b_t30_32", timer_30_out, 22);
      t30_start = 1'b0;
      step(1);

      // 6: reset mid-count
      t30_start = 1'b1;
      step(1);
      step(72);
      chk("rr_12", timer_30_out, 12);
      reset = 1'b0;
      t30_start = 1'b0;
      step(1);
      chk("rr_t30", timer_30_out, 30);
      chk("rr_pe", play_expired, 0);
      reset = 1'b1;
      pulses = 0;
      bad = 0;
      for (int i = 0; i < 150; i++) begin
         step(1);
         if (play_expired) pulses++;
         if (timer_30_out != 30) bad++;
      end
      chk("rr_no_pulse", pulses, 0);
      chk("rr_idle_bad", bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/game_countdown_timers.md
Name: game_countdown_timers

Overview:
- Generates the two countdowns the game controller consumes: the 5-second "get ready" countdown and the 30-second per-level play countdown.
- Counts seconds from the system clock via per-timer prescalers.
- Driven by the controller's timer_5_start / timer_30_start requests; its count values feed back to the controller's timer_5_in / timer_30_in.
- Also drives one-cycle expiry pulses for the display and sound blocks.

Parameters:
- TICK_DIV, 100000000, clk cycles per one-second tick (set to 4 in simulation).
- READY_SECS, 5, ready countdown start value; range 1..7.
- PLAY_SECS, 30, play countdown start value; range 1..31.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset reset, synchronous, active-low; clock clk.
- timer_5_start  in  1  run request for the ready countdown (level-held).
- timer_30_start  in  1  run request for the play countdown (level-held).
- pause  in  1  freezes both prescalers while high.
- timer_5_out  out  3  ready countdown seconds remaining.
- timer_30_out  out  5  play countdown seconds remaining.
- ready_done  out  1  one-cycle pulse when the ready count reaches 0.
- play_expired  out  1  one-cycle pulse when the play count reaches 0.

Behaviour:
- Two identical, independent timer channels (R: ready, P: play). Each channel has its own prescaler, width clog2(TICK_DIV), and its own 3-state FSM: IDLE, RUN, DONE. All outputs are registered.
- Reset (reset==0 at a clk edge), including mid-count, sets:
  - both FSMs to IDLE, both prescalers to 0;
  - timer_5_out=READY_SECS, timer_30_out=PLAY_SECS;
  - ready_done=0, play_expired=0.
  - Reset overrides every other input.
- IDLE:
  - Count holds its load value (READY_SECS / PLAY_SECS); prescaler held at 0.
  - start sampled 1 -> RUN on that edge; count = load value, prescaler = 0.
- RUN:
  - Each edge with pause==0: if prescaler==TICK_DIV-1, then prescaler<=0 and count<=count-1; else prescaler<=prescaler+1.
  - First decrement occurs exactly TICK_DIV edges after the edge that entered RUN (pause excluded).
  - With pause==1: prescaler and count hold.
  - A decrement from 1 to 0 moves the FSM to DONE and asserts the channel's done pulse (ready_done / play_expired) on the same edge, for exactly one cycle.
  - start sampled 0 -> IDLE; count reloads the load value; prescaler=0; no pulse. Abort takes priority over a same-edge decrement.
- DONE:
  - Count holds 0; prescaler stopped; pulse deasserted after one cycle.
  - start sampled 0 -> IDLE with count reloaded to the load value.
  - A channel never re-runs without start first being seen low for at least one cycle.
- Arithmetic:
  - Counts are unsigned and never wrap below 0.
  - The prescaler wraps TICK_DIV-1 -> 0 only in RUN.
- Channel independence:
  - Both starts high together -> both channels run concurrently on separate prescalers.
  - Starting one channel does not disturb the other's prescaler.
- pause:
  - No effect in IDLE or DONE.
  - pause high on the IDLE->RUN edge still loads the count; prescaler stays at 0 until pause drops.
- Output latency: a count change is visible on the outputs one clk after the qualifying edge (registered); there is no combinational path from inputs to outputs.

Test Plan:
(All scenarios run with TICK_DIV=4, READY_SECS=5, PLAY_SECS=30.)
1. Reset low 2 cycles, then high with starts low -> timer_5_out=5, timer_30_out=30, both pulses 0, values stable for 20 cycles.
2. timer_5_start=1 held -> timer_5_out steps 5,4,3,2,1,0, one step every 4 cycles. ready_done is high exactly one cycle, coincident with the 0 value; the count holds 0 for 10 further cycles. Dropping start then gives timer_5_out=5 on the next cycle.
3. timer_30_start=1 held for 120 cycles -> play_expired pulses once at cycle 120 and timer_30_out=0. A start re-raised without a low cycle does not restart the count.
4. timer_30_start=1; pause=1 for 9 cycles after count reaches 27 -> the count stays 27 for the pause duration. The next decrement lands 4 unpaused cycles after the previous one.
5. Both starts raised on the same edge -> ready_done fires at cycle 20 with timer_30_out=25 at that point. Dropping timer_5_start mid-run (count=3) reloads 5 with no pulse, and timer_30_out keeps counting.
6. Reset asserted while timer_30_out=12 in RUN -> on the next edge timer_30_out=30 and FSM is IDLE. No play_expired pulse ever follows without a new start.
